// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
//   Sequential signed WIDTH x WIDTH radix-2 Booth multiplier controller.
//   It does no addition itself. Each RUN cycle it drives an external
//   carry-lookahead adder. It then folds that adder's sum and carry-out back
//   into a 2*WIDTH-bit accumulator {hi,lo} with an arithmetic right shift.
//   The low word and a signed-overflow flag are returned together with a
//   one-cycle ready pulse.
//
// Ports
//   clock, resetn                   rising-edge clock, async active-low reset
//   ctrl_MULT                       start pulse; samples both operands
//   data_operandA / data_operandB   multiplicand M / multiplier Q (signed)
//   adder_a/b/g/p/c0                operands, generate, propagate, carry-in to adder
//   adder_sum / adder_cout          adder result and carry out of the MSB
//   data_result                     low WIDTH bits of the product
//   data_exception                  product does not fit in signed WIDTH bits
//   data_resultRDY                  one-cycle pulse, result/exception valid
// ---------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] adder_g,
  output logic [WIDTH-1:0] adder_p,
  output logic             adder_c0,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  logic             sign_ext;
  logic [WIDTH-1:0] hi_shift;
  logic [WIDTH-1:0] lo_shift;

  // Adder operand selection from the Booth pair {lo[0], q_1}.
  always_comb begin
    adder_a  = '0;
    adder_b  = '0;
    adder_c0 = 1'b0;
    if (state_q == RUN) begin
      adder_a = hi_q;
      unique case ({lo_q[0], q1_q})
        2'b01:   adder_b = m_q;
        2'b10:   begin adder_b = ~m_q; adder_c0 = 1'b1; end
        default: adder_b = '0;
      endcase
    end
  end

  assign adder_g = adder_a & adder_b;
  assign adder_p = adder_a | adder_b;

  // The 33rd sum bit is recovered from the operand MSBs and the carry-out.
  // Without it, hi would overflow on 0x80000000 operands.
  assign sign_ext = adder_a[WIDTH-1] ^ adder_b[WIDTH-1] ^ adder_cout;
  assign hi_shift = {sign_ext, adder_sum[WIDTH-1:1]};
  assign lo_shift = {adder_sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    state_d        = state_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    m_d            = m_q;
    q1_d           = q1_q;
    cnt_d          = cnt_q;
    res_d          = res_q;
    exc_d          = exc_q;
    data_resultRDY = (state_q == DONE);

    unique case (state_q)
      IDLE: ;
      RUN: begin
        hi_d  = hi_shift;
        lo_d  = lo_shift;
        q1_d  = lo_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          // The result is captured from the final shifted values on the same
          // edge that enters DONE.
          res_d   = lo_shift;
          exc_d   = (hi_shift != {WIDTH{lo_shift[WIDTH-1]}});
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in any state reloads the operands. In RUN it aborts the current op.
    if (ctrl_MULT) begin
      state_d = RUN;
      m_d     = data_operandA;
      lo_d    = data_operandB;
      hi_d    = '0;
      q1_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;

endmodule
